// File: rtl/serv_csr_irq_if.sv
// Serial CSR / interrupt bundle between the SERV core and serv_csr_irq.
// The core side is the master; the CSR unit is the slave.
interface serv_csr_irq_if #(
    parameter int NUM_LOCAL_IRQ = 4
);
    localparam int LW = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1;

    logic          i_en;
    logic [4:0]    i_cnt;
    logic          i_mstatus_en;
    logic          i_mie_en;
    logic          i_mip_en;
    logic          i_mcause_en;
    logic [1:0]    i_csr_source;
    logic          i_d;
    logic          i_rf_csr_out;
    logic          o_csr_in;
    logic          o_q;
    logic          i_msip;
    logic          i_mtip;
    logic          i_meip;
    logic [LW-1:0] i_irq_local;
    logic          o_new_irq;
    logic          i_trap_taken;
    logic          i_pending_irq;
    logic          i_e_op;
    logic          i_ebreak;
    logic          i_mem_misalign;
    logic          i_mem_cmd;
    logic          i_mret;

    modport master (
        output i_en, i_cnt, i_mstatus_en, i_mie_en, i_mip_en,
        output i_mcause_en, i_csr_source, i_d, i_rf_csr_out,
        output i_msip, i_mtip, i_meip, i_irq_local,
        output i_trap_taken, i_pending_irq, i_e_op, i_ebreak,
        output i_mem_misalign, i_mem_cmd, i_mret,
        input  o_csr_in, o_q, o_new_irq
    );

    modport slave (
        input  i_en, i_cnt, i_mstatus_en, i_mie_en, i_mip_en,
        input  i_mcause_en, i_csr_source, i_d, i_rf_csr_out,
        input  i_msip, i_mtip, i_meip, i_irq_local,
        input  i_trap_taken, i_pending_irq, i_e_op, i_ebreak,
        input  i_mem_misalign, i_mem_cmd, i_mret,
        output o_csr_in, o_q, o_new_irq
    );
endinterface

// File: rtl/serv_csr_irq.sv
// Bit-serial machine-mode CSR and interrupt unit for SERV.
// Optional macro SERV_CSR_IRQ_SYNC_EN adds a 2-flop synchroniser on irq inputs.
module serv_csr_irq #(
    parameter int NUM_LOCAL_IRQ = 4
) (
    input logic           i_clk,
    input logic           i_rst_n,
    serv_csr_irq_if.slave bus
);
    localparam logic [1:0] SRC_CSR = 2'b00;
    localparam logic [1:0] SRC_EXT = 2'b01;
    localparam logic [1:0] SRC_SET = 2'b10;
    localparam logic [1:0] SRC_CLR = 2'b11;

    localparam logic [31:0] LOC_MASK =
        ((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << 16;
    localparam logic [31:0] IMPL = LOC_MASK | 32'h0000_0888;

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mip_q, mip_d;
    logic        mcause_irq_q, mcause_irq_d;
    logic [4:0]  mcause_code_q, mcause_code_d;
    logic        deliv_q, deliv_d;
    logic [31:0] pins;
    logic [31:0] mstatus_vec;
    logic [31:0] mcause_vec;
    logic [31:0] pend;
    logic [4:0]  win_code;
    logic        sel_bit;
    logic        csr_out;
    logic        csr_in;
    logic        new_irq;

    // Gather interrupt levels into their mip bit positions.
    always_comb begin
        pins     = '0;
        pins[3]  = bus.i_msip;
        pins[7]  = bus.i_mtip;
        pins[11] = bus.i_meip;
        for (int k = 0; k < NUM_LOCAL_IRQ; k++)
            pins[16+k] = bus.i_irq_local[k];
    end

    // Serial read mux and read-modify-write data.
    always_comb begin
        mstatus_vec    = '0;
        mstatus_vec[3] = mstatus_mie_q;
        mstatus_vec[7] = mstatus_mpie_q;
        mcause_vec     = {mcause_irq_q, 26'd0, mcause_code_q};
        sel_bit        = 1'b0;
        unique case (1'b1)
            bus.i_mstatus_en: sel_bit = mstatus_vec[bus.i_cnt];
            bus.i_mie_en:     sel_bit = mie_q[bus.i_cnt];
            bus.i_mip_en:     sel_bit = mip_q[bus.i_cnt];
            bus.i_mcause_en:  sel_bit = mcause_vec[bus.i_cnt];
            default:          sel_bit = 1'b0;
        endcase
        csr_out = (bus.i_en & sel_bit) | bus.i_rf_csr_out;
        csr_in  = csr_out;
        case (bus.i_csr_source)
            SRC_EXT: csr_in = bus.i_d;
            SRC_SET: csr_in = csr_out | bus.i_d;
            SRC_CLR: csr_in = csr_out & ~bus.i_d;
            SRC_CSR: csr_in = csr_out;
            default: csr_in = csr_out;
        endcase
    end

    // Pick the winning pending+enabled interrupt: MEI, MSI, MTI, then locals.
    always_comb begin
        pend     = mip_q & mie_q;
        win_code = 5'd0;
        for (int k = NUM_LOCAL_IRQ - 1; k >= 0; k--)
            if (pend[16+k])
                win_code = 5'(16 + k);
        if (pend[7])
            win_code = 5'd7;
        if (pend[3])
            win_code = 5'd3;
        if (pend[11])
            win_code = 5'd11;
    end

    // Next-state: serial writes, then mret, then trap entry (highest).
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mcause_irq_d   = mcause_irq_q;
        mcause_code_d  = mcause_code_q;
        deliv_d        = mstatus_mie_q & (|(mip_q & mie_q));
        if (bus.i_en & bus.i_mstatus_en) begin
            if (bus.i_cnt == 5'd3)
                mstatus_mie_d = csr_in;
            if (bus.i_cnt == 5'd7)
                mstatus_mpie_d = csr_in;
        end
        if (bus.i_en & bus.i_mie_en & IMPL[bus.i_cnt])
            mie_d[bus.i_cnt] = csr_in;
        if (bus.i_en & bus.i_mcause_en) begin
            if (bus.i_cnt < 5'd5)
                mcause_code_d[bus.i_cnt[2:0]] = csr_in;
            if (bus.i_cnt == 5'd31)
                mcause_irq_d = csr_in;
        end
        if (bus.i_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
        if (bus.i_trap_taken) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mcause_irq_d   = bus.i_pending_irq;
            if (bus.i_pending_irq)
                mcause_code_d = win_code;
            else if (bus.i_e_op)
                mcause_code_d = bus.i_ebreak ? 5'd3 : 5'd11;
            else if (bus.i_mem_misalign)
                mcause_code_d = bus.i_mem_cmd ? 5'd6 : 5'd4;
            else
                mcause_code_d = 5'd0;
        end
    end

    // CSR state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mcause_irq_q   <= 1'b0;
            mcause_code_q  <= '0;
            deliv_q        <= 1'b0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mcause_irq_q   <= mcause_irq_d;
            mcause_code_q  <= mcause_code_d;
            deliv_q        <= deliv_d;
        end
    end

`ifdef SERV_CSR_IRQ_SYNC_EN
    logic [31:0] sync_q, sync_d;
    logic        new_irq_q, new_irq_d;

    // Two-flop synchroniser feeds mip; the edge pulse is registered.
    always_comb begin
        sync_d    = pins;
        mip_d     = sync_q;
        new_irq_d = deliv_d & ~deliv_q;
        new_irq   = new_irq_q;
    end

    // Synchroniser and pulse registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q    <= '0;
            mip_q     <= '0;
            new_irq_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            mip_q     <= mip_d;
            new_irq_q <= new_irq_d;
        end
    end
`else
    // Inputs already synchronous: single capture stage, comb edge detect.
    always_comb begin
        mip_d   = pins;
        new_irq = deliv_d & ~deliv_q;
    end

    // mip capture register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            mip_q <= '0;
        else
            mip_q <= mip_d;
    end
`endif

    assign bus.o_q       = csr_out;
    assign bus.o_csr_in  = csr_in;
    assign bus.o_new_irq = new_irq;
endmodule

// File: tb/tb_serv_csr_irq.sv
// Self-checking bench for serv_csr_irq: vector table, corner sequences,
// and randomised traffic against a behavioural CSR model.
module tb_serv_csr_irq;
    localparam int NL = 4;
`ifdef SERV_CSR_IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int C_MSTATUS = 0;
    localparam int C_MIE     = 1;
    localparam int C_MIP     = 2;
    localparam int C_MCAUSE  = 3;
    localparam logic [1:0] S_CSR = 2'b00;
    localparam logic [1:0] S_EXT = 2'b01;
    localparam logic [1:0] S_SET = 2'b10;
    localparam logic [1:0] S_CLR = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serv_csr_irq_if #(.NUM_LOCAL_IRQ(NL)) bus ();
    serv_csr_irq #(.NUM_LOCAL_IRQ(NL)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic        m_mie, m_mpie, m_irq;
    logic [4:0]  m_code;
    logic [31:0] m_mier, m_pins, impl;

    typedef struct {
        logic [31:0] mie;
        logic [31:0] pins;
        logic        pend, eop, ebk, mis, cmd;
        logic [31:0] exp;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.i_en = 0; bus.i_cnt = 0; bus.i_d = 0;
        bus.i_mstatus_en = 0; bus.i_mie_en = 0;
        bus.i_mip_en = 0; bus.i_mcause_en = 0;
        bus.i_csr_source = S_CSR; bus.i_rf_csr_out = 0;
        bus.i_trap_taken = 0; bus.i_pending_irq = 0;
        bus.i_e_op = 0; bus.i_ebreak = 0;
        bus.i_mem_misalign = 0; bus.i_mem_cmd = 0; bus.i_mret = 0;
    endtask

    task automatic sel(input int csr);
        bus.i_mstatus_en = (csr == C_MSTATUS);
        bus.i_mie_en     = (csr == C_MIE);
        bus.i_mip_en     = (csr == C_MIP);
        bus.i_mcause_en  = (csr == C_MCAUSE);
    endtask

    task automatic csr_op(input int csr, input logic [1:0] src,
                          input logic [31:0] w, output logic [31:0] r);
        r = '0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bus.i_en = 1; bus.i_cnt = 5'(i); sel(csr);
            bus.i_csr_source = src; bus.i_d = w[i];
            #1 r[i] = bus.o_q;
        end
        @(negedge clk);
        idle();
    endtask

    function automatic logic [31:0] m_read(input int csr);
        case (csr)
            C_MSTATUS: return {24'd0, m_mpie, 3'd0, m_mie, 3'd0};
            C_MIE:     return m_mier;
            C_MIP:     return m_pins & impl;
            default:   return {m_irq, 26'd0, m_code};
        endcase
    endfunction

    task automatic m_write(input int csr, input logic [1:0] src,
                           input logic [31:0] w);
        logic [31:0] o, n;
        o = m_read(csr);
        case (src)
            S_EXT:   n = w;
            S_SET:   n = o | w;
            S_CLR:   n = o & ~w;
            default: n = o;
        endcase
        case (csr)
            C_MSTATUS: begin m_mie = n[3]; m_mpie = n[7]; end
            C_MIE:     m_mier = n & impl;
            C_MCAUSE:  begin m_irq = n[31]; m_code = n[4:0]; end
            default:   ;
        endcase
    endtask

    task automatic do_op(input string name, input int csr,
                         input logic [1:0] src, input logic [31:0] w);
        logic [31:0] r;
        csr_op(csr, src, w, r);
        chk(name, r, m_read(csr));
        m_write(csr, src, w);
    endtask

    function automatic logic [4:0] m_winner();
        logic [31:0] p;
        int order[3];
        p = m_pins & impl & m_mier;
        order = '{11, 3, 7};
        foreach (order[j])
            if (p[order[j]]) return 5'(order[j]);
        for (int k = 0; k < NL; k++)
            if (p[16+k]) return 5'(16 + k);
        return 5'd0;
    endfunction

    task automatic set_pins(input logic [31:0] p);
        @(negedge clk);
        bus.i_msip = p[3]; bus.i_mtip = p[7]; bus.i_meip = p[11];
        for (int k = 0; k < NL; k++) bus.i_irq_local[k] = p[16+k];
        m_pins = p & impl;
        repeat (3) @(negedge clk);
    endtask

    task automatic trap(input logic pend, eop, ebk, mis, cmd);
        @(negedge clk);
        bus.i_trap_taken = 1; bus.i_pending_irq = pend;
        bus.i_e_op = eop; bus.i_ebreak = ebk;
        bus.i_mem_misalign = mis; bus.i_mem_cmd = cmd;
        @(negedge clk);
        idle();
        m_irq = pend;
        if (pend) m_code = m_winner();
        else if (eop) m_code = ebk ? 5'd3 : 5'd11;
        else if (mis) m_code = cmd ? 5'd6 : 5'd4;
        else m_code = 5'd0;
        m_mpie = m_mie; m_mie = 0;
    endtask

    task automatic mret();
        @(negedge clk);
        bus.i_mret = 1;
        @(negedge clk);
        idle();
        m_mie = m_mpie; m_mpie = 1;
    endtask

    task automatic m_reset();
        m_mie = 0; m_mpie = 0; m_irq = 0; m_code = 0; m_mier = 0;
    endtask

    initial begin
        logic [31:0] r;
        int first, pulses;
        impl = 32'h888;
        for (int k = 0; k < NL; k++) impl[16+k] = 1'b1;
        tv[0]  = '{32'h888,   32'h888,   1, 0, 0, 0, 0, 32'h8000000B};
        tv[1]  = '{32'h888,   32'h088,   1, 0, 0, 0, 0, 32'h80000003};
        tv[2]  = '{32'h080,   32'h080,   1, 0, 0, 0, 0, 32'h80000007};
        tv[3]  = '{32'h40000, 32'hC0000, 1, 0, 0, 0, 0, 32'h80000012};
        tv[4]  = '{32'hF0000, 32'hA0000, 1, 0, 0, 0, 0, 32'h80000011};
        tv[5]  = '{32'hF0888, 32'h30080, 1, 0, 0, 0, 0, 32'h80000007};
        tv[6]  = '{32'h0,     32'h888,   1, 0, 0, 0, 0, 32'h80000000};
        tv[7]  = '{32'h0,     32'h0,     0, 1, 1, 0, 0, 32'h00000003};
        tv[8]  = '{32'h0,     32'h0,     0, 1, 0, 0, 0, 32'h0000000B};
        tv[9]  = '{32'h0,     32'h0,     0, 0, 0, 1, 1, 32'h00000006};
        tv[10] = '{32'h0,     32'h0,     0, 0, 0, 1, 0, 32'h00000004};
        tv[11] = '{32'h0,     32'h0,     0, 0, 0, 0, 0, 32'h00000000};

        idle();
        bus.i_msip = 0; bus.i_mtip = 0; bus.i_meip = 0;
        bus.i_irq_local = '0;
        m_reset(); m_pins = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;

        csr_op(C_MSTATUS, S_CSR, 0, r); chk("rst mstatus", r, 0);
        csr_op(C_MIE, S_CSR, 0, r);     chk("rst mie", r, 0);
        csr_op(C_MCAUSE, S_CSR, 0, r);  chk("rst mcause", r, 0);
        chk("rst new_irq", 32'(bus.o_new_irq), 0);

        // read-modify-write ops on mie and write attempts on mip
        do_op("mie ext", C_MIE, S_EXT, 32'h8);
        do_op("mie set", C_MIE, S_SET, 32'h80);
        csr_op(C_MIE, S_CSR, 0, r);  chk("mie after set", r, 32'h88);
        do_op("mie clr", C_MIE, S_CLR, 32'h80);
        csr_op(C_MIE, S_CSR, 0, r);  chk("mie after clr", r, 32'h8);
        do_op("mie ext all", C_MIE, S_EXT, 32'hFFFF_FFFF);
        csr_op(C_MIE, S_CSR, 0, r);  chk("mie impl", r, 32'h000F_0888);
        do_op("mip wr", C_MIP, S_EXT, 32'hFFFF_FFFF);
        csr_op(C_MIP, S_CSR, 0, r);  chk("mip ro", r, 0);

        // RF-resident CSR path
        @(negedge clk);
        bus.i_rf_csr_out = 1; bus.i_csr_source = S_CLR; bus.i_d = 1;
        #1 chk("rf q", 32'(bus.o_q), 1);
        chk("rf clr", 32'(bus.o_csr_in), 0);
        bus.i_csr_source = S_SET; bus.i_d = 0;
        #1 chk("rf set", 32'(bus.o_csr_in), 1);
        idle();

        // new interrupt edge: one pulse, LAT cycles after the pin
        do_op("en mie", C_MSTATUS, S_EXT, 32'h8);
        do_op("en mtie", C_MIE, S_EXT, 32'h80);
        @(negedge clk);
        bus.i_mtip = 1;
        first = -1; pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1 if (bus.o_new_irq) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        chk("new_irq lat", 32'(first), 32'(LAT));
        chk("new_irq cnt", 32'(pulses), 1);
        set_pins(0);
        do_op("dis mie", C_MSTATUS, S_EXT, 32'h0);
        @(negedge clk);
        bus.i_mtip = 1;
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1 if (bus.o_new_irq) pulses++;
        end
        chk("new_irq masked", 32'(pulses), 0);
        set_pins(0);

        // trap cause table
        for (int i = 0; i < 12; i++) begin
            do_op("tv mie", C_MIE, S_EXT, tv[i].mie);
            do_op("tv mst", C_MSTATUS, S_EXT, 32'h8);
            set_pins(tv[i].pins);
            trap(tv[i].pend, tv[i].eop, tv[i].ebk, tv[i].mis, tv[i].cmd);
            csr_op(C_MCAUSE, S_CSR, 0, r);
            chk($sformatf("tv%0d mcause", i), r, tv[i].exp);
            csr_op(C_MSTATUS, S_CSR, 0, r);
            chk($sformatf("tv%0d mstatus", i), r, 32'h80);
        end
        set_pins(0);

        // trap in the same cycle as a serial MIE write
        do_op("pre mst", C_MSTATUS, S_EXT, 32'h8);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bus.i_en = 1; bus.i_cnt = 5'(i); sel(C_MSTATUS);
            bus.i_csr_source = S_EXT; bus.i_d = (i == 3);
            bus.i_trap_taken = (i == 3);
            bus.i_e_op = (i == 3); bus.i_ebreak = (i == 3);
        end
        @(negedge clk);
        idle();
        m_mie = 0; m_mpie = 0; m_irq = 0; m_code = 5'd3;
        csr_op(C_MSTATUS, S_CSR, 0, r); chk("trap vs wr", r, 0);
        csr_op(C_MCAUSE, S_CSR, 0, r);  chk("trap vs wr cause", r, 3);

        // mret restores MIE from MPIE and sets MPIE
        do_op("mret pre", C_MSTATUS, S_EXT, 32'h8);
        trap(0, 1, 0, 0, 0);
        mret();
        csr_op(C_MSTATUS, S_CSR, 0, r); chk("mret a", r, 32'h88);
        do_op("mret pre2", C_MSTATUS, S_EXT, 32'h8);
        mret();
        csr_op(C_MSTATUS, S_CSR, 0, r); chk("mret b", r, 32'h80);

        // randomised traffic against the model
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: do_op("rnd op", int'($urandom_range(0, 3)),
                               2'($urandom_range(0, 3)), $urandom);
                3: set_pins($urandom & impl);
                4: begin
                    trap(1'($urandom), 1'($urandom), 1'($urandom),
                         1'($urandom), 1'($urandom));
                    do_op("rnd cause", C_MCAUSE, S_CSR, 0);
                end
                default: begin
                    mret();
                    do_op("rnd mret", C_MSTATUS, S_CSR, 0);
                end
            endcase
        end
        set_pins(0);

        // reset in the middle of a transfer
        do_op("pre rst", C_MIE, S_EXT, 32'h888);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.i_en = 1; bus.i_cnt = 5'(i); sel(C_MSTATUS);
            bus.i_csr_source = S_EXT; bus.i_d = 1;
        end
        @(posedge clk);
        #3 rst_n = 0;
        #1 chk("mid rst new_irq", 32'(bus.o_new_irq), 0);
        @(negedge clk);
        idle();
        rst_n = 1;
        m_reset();
        csr_op(C_MSTATUS, S_CSR, 0, r); chk("rst2 mstatus", r, 0);
        csr_op(C_MIE, S_CSR, 0, r);     chk("rst2 mie", r, 0);
        csr_op(C_MCAUSE, S_CSR, 0, r);  chk("rst2 mcause", r, 0);
        do_op("post rst wr", C_MIE, S_EXT, 32'h800);
        csr_op(C_MIE, S_CSR, 0, r);     chk("post rst rd", r, 32'h800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout actual running expected finished");
        $fatal(1);
    end
endmodule
